// File: rtl/neuron_sequencer_pkg.sv
// Shared types and widths for the time-multiplexed neuron sequencer.
package neuron_sequencer_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 17;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT
    } state_t;

    function automatic logic signed [RESW-1:0] apply_relu(
        input logic signed [RESW-1:0] r,
        input logic                   en
    );
        if (en && r[RESW-1]) begin
            return '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_sequencer.sv
// Sequences NUM_NEURONS logical neurons through one external physical neuron,
// one weight pair per logical neuron, emitting one result per logical neuron.
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NEURON_LAT  = 2,
    localparam int IDXW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [IDXW-1:0]        cfg_addr,
    input  logic signed [OPW-1:0]  cfg_w1,
    input  logic signed [OPW-1:0]  cfg_w2,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [OPW-1:0]  in_x1,
    input  logic signed [OPW-1:0]  in_x2,
    input  logic                   relu_en,
    output logic signed [OPW-1:0]  nrn_i1,
    output logic signed [OPW-1:0]  nrn_i2,
    output logic signed [OPW-1:0]  nrn_w1,
    output logic signed [OPW-1:0]  nrn_w2,
    input  logic signed [RESW-1:0] nrn_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDXW-1:0]        out_idx,
    output logic signed [RESW-1:0] out_data,
    output logic                   busy
);

    localparam int              CNTW     = (NEURON_LAT > 0) ? $clog2(NEURON_LAT + 1) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

    logic signed [OPW-1:0]  w1_arr [NUM_NEURONS];
    logic signed [OPW-1:0]  w2_arr [NUM_NEURONS];

    state_t                 state_reg;
    logic [IDXW-1:0]        idx_reg;
    logic [CNTW-1:0]        cnt_reg;
    logic signed [OPW-1:0]  x1_reg, x2_reg;
    logic signed [OPW-1:0]  i1_reg, i2_reg, w1_reg, w2_reg;
    logic signed [RESW-1:0] out_data_reg;
    logic                   out_valid_reg;

    logic                   wr_en;
    logic                   wr_bypass0;
    logic [IDXW-1:0]        idx_next;

    assign wr_en      = cfg_we && (state_reg == IDLE);
    // A write landing on neuron 0 in the accepting cycle must reach the first ISSUE.
    assign wr_bypass0 = wr_en && (cfg_addr == '0);
    assign idx_next   = idx_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                w1_arr[i] <= '0;
                w2_arr[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (int'(cfg_addr) == i) begin
                    w1_arr[i] <= cfg_w1;
                    w2_arr[i] <= cfg_w2;
                end
            end
        end
    end

    // Operands are loaded on ISSUE entry and held until the EMIT handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            x1_reg        <= '0;
            x2_reg        <= '0;
            i1_reg        <= '0;
            i2_reg        <= '0;
            w1_reg        <= '0;
            w2_reg        <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x1_reg    <= in_x1;
                        x2_reg    <= in_x2;
                        i1_reg    <= in_x1;
                        i2_reg    <= in_x2;
                        w1_reg    <= wr_bypass0 ? cfg_w1 : w1_arr[0];
                        w2_reg    <= wr_bypass0 ? cfg_w2 : w2_arr[0];
                        idx_reg   <= '0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= CNTW'(NEURON_LAT);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg <= CNTW'(1)) begin
                        out_data_reg  <= apply_relu(nrn_result, relu_en);
                        out_valid_reg <= 1'b1;
                        state_reg     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_next;
                            i1_reg    <= x1_reg;
                            i2_reg    <= x2_reg;
                            w1_reg    <= w1_arr[idx_next];
                            w2_reg    <= w2_arr[idx_next];
                            state_reg <= ISSUE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign nrn_i1    = i1_reg;
    assign nrn_i2    = i2_reg;
    assign nrn_w1    = w1_reg;
    assign nrn_w2    = w2_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = idx_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a pipelined multiply-accumulate neuron model.
module tb_neuron_sequencer;

    localparam int N = 4;
    localparam int L = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic signed [7:0]  cfg_w1, cfg_w2;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_x1, in_x2;
    logic               relu_en;
    logic signed [7:0]  nrn_i1, nrn_i2, nrn_w1, nrn_w2;
    logic signed [16:0] nrn_result;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_idx;
    logic signed [16:0] out_data;
    logic               busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    neuron_sequencer #(.NUM_NEURONS(N), .NEURON_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w1(cfg_w1), .cfg_w2(cfg_w2),
        .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
        .relu_en(relu_en),
        .nrn_i1(nrn_i1), .nrn_i2(nrn_i2), .nrn_w1(nrn_w1), .nrn_w2(nrn_w2),
        .nrn_result(nrn_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .busy(busy)
    );

    // Physical neuron: i1*w1 + i2*w2 through L pipeline registers.
    function automatic logic signed [16:0] mac(input logic signed [7:0] a, b, c, d);
        logic signed [16:0] ea, eb, ec, ed;
        ea = {{9{a[7]}}, a};
        eb = {{9{b[7]}}, b};
        ec = {{9{c[7]}}, c};
        ed = {{9{d[7]}}, d};
        return ea * eb + ec * ed;
    endfunction

    logic signed [16:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= mac(nrn_i1, nrn_w1, nrn_i2, nrn_w2);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign nrn_result = pipe[L-1];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic signed [7:0] w1, input logic signed [7:0] w2);
        cfg_we = 1'b1; cfg_addr = a; cfg_w1 = w1; cfg_w2 = w2;
        tick();
        cfg_we = 1'b0;
    endtask

    // One full pass; edges are counted with the acceptance edge as edge 1.
    task automatic run_pass(input string name,
                            input logic signed [7:0] x1, input logic signed [7:0] x2,
                            input logic relu,
                            input int e0, input int e1, input int e2, input int e3,
                            input int hold_idx, input logic busy_wr, input logic acc_wr);
        int exp_v[4];
        int edges, last_edge, n;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        relu_en  = relu;
        in_x1    = x1;
        in_x2    = x2;
        in_valid = 1'b1;
        if (acc_wr) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_w1 = 8'sd7; cfg_w2 = 8'sd7;
        end
        check({name, "_ready_before"}, 32'(in_ready), 1);
        tick();
        edges     = 1;
        last_edge = 0;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        check({name, "_busy"}, 32'(busy), 1);
        check({name, "_not_ready"}, 32'(in_ready), 0);
        if (busy_wr) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_w1 = 8'sd7; cfg_w2 = 8'sd7;
            in_valid = 1'b1; in_x1 = -8'sd9; in_x2 = 8'sd11;
            tick();
            edges++;
            cfg_we = 1'b0; in_valid = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                edges++;
                n++;
            end
            check($sformatf("%s_valid%0d", name, k), 32'(out_valid), 1);
            if (k == 0)
                check({name, "_latency"}, edges, L + 2);
            else if (k != hold_idx + 1)
                check($sformatf("%s_period%0d", name, k), edges - last_edge, L + 2);
            check($sformatf("%s_idx%0d", name, k), 32'(out_idx), k);
            check($sformatf("%s_data%0d", name, k), 32'(out_data), exp_v[k]);
            $display("%s: idx=%0d data=%0d edge=%0d", name, out_idx, out_data, edges);
            if (k == hold_idx) begin
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    edges++;
                    check($sformatf("%s_hold_valid%0d", name, h), 32'(out_valid), 1);
                    check($sformatf("%s_hold_idx%0d", name, h), 32'(out_idx), 1);
                    check($sformatf("%s_hold_data%0d", name, h), 32'(out_data), -19);
                    check($sformatf("%s_hold_w1_%0d", name, h), 32'(nrn_w1), -2);
                    check($sformatf("%s_hold_w2_%0d", name, h), 32'(nrn_w2), -3);
                    check($sformatf("%s_hold_i1_%0d", name, h), 32'(nrn_i1), 5);
                    check($sformatf("%s_hold_i2_%0d", name, h), 32'(nrn_i2), 3);
                end
                out_ready = 1'b1;
            end
            last_edge = edges;
            tick();
            edges++;
            check($sformatf("%s_drop%0d", name, k), 32'(out_valid), 0);
        end
        check({name, "_idle_busy"}, 32'(busy), 0);
        check({name, "_idle_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        reset     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_w1    = '0;
        cfg_w2    = '0;
        in_valid  = 1'b0;
        in_x1     = '0;
        in_x2     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_nrn_w1", 32'(nrn_w1), 0);
        check("rst_nrn_i1", 32'(nrn_i1), 0);
        tick();
        tick();
        reset = 1'b1;
        check("rel_ready", 32'(in_ready), 1);

        cfg_write(2'd0, 8'sd2, 8'sd4);
        cfg_write(2'd1, -8'sd2, -8'sd3);
        cfg_write(2'd2, -8'sd4, -8'sd5);
        cfg_write(2'd3, 8'sd1, 8'sd1);

        run_pass("plain", 8'sd5, 8'sd3, 1'b0, 22, -19, -35, 8, -5, 1'b0, 1'b0);
        run_pass("relu", 8'sd5, 8'sd3, 1'b1, 22, 0, 0, 8, -5, 1'b0, 1'b0);
        run_pass("hold", 8'sd5, 8'sd3, 1'b0, 22, -19, -35, 8, 1, 1'b0, 1'b0);
        run_pass("busywr", 8'sd5, 8'sd3, 1'b0, 22, -19, -35, 8, -5, 1'b1, 1'b0);
        run_pass("afterbusy", 8'sd5, 8'sd3, 1'b0, 22, -19, -35, 8, -5, 1'b0, 1'b0);
        run_pass("accwr", 8'sd5, 8'sd3, 1'b0, 56, -19, -35, 8, -5, 1'b0, 1'b1);

        // Abort a pass while idx 2 is waiting on the neuron.
        relu_en  = 1'b0;
        in_x1    = 8'sd5;
        in_x2    = 8'sd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("abort_pre_idx", 32'(out_idx), 2);
        check("abort_pre_valid", 32'(out_valid), 0);
        check("abort_pre_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_idx", 32'(out_idx), 0);
        tick();
        tick();
        check("abort_hold_valid", 32'(out_valid), 0);
        reset = 1'b1;
        check("abort_rel_ready", 32'(in_ready), 1);
        check("abort_rel_busy", 32'(busy), 0);
        run_pass("cleared", 8'sd5, 8'sd3, 1'b0, 0, 0, 0, 0, -5, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) cfg_write(2'(i), -8'sd128, -8'sd128);
        run_pass("extneg", -8'sd128, -8'sd128, 1'b0, 32768, 32768, 32768, 32768, -5, 1'b0, 1'b0);
        run_pass("extpos", 8'sd127, 8'sd127, 1'b0, -32512, -32512, -32512, -32512, -5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
